// File: rtl/stream_mux_arb.sv
// Registered N-channel stream mux with round-robin/burst, fixed-priority or manual arbitration.
// One cycle latency; a held beat with out_ready low drops every in_ready until it is popped.
module stream_mux_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int MODE  = 0,
  parameter int BURST = 1,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CNTW = $clog2(BURST) + 1;

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] owner;
  logic [SELW-1:0] gidx;
  logic [SELW-1:0] scan_idx;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;
  logic [NCH-1:0]  grant;
  logic            gany;
  logic            locked;
  logic            load;
  logic            xfer;
  int              burst_c;

  assign load = !out_valid || out_ready;

  always_comb begin
    gany     = 1'b0;
    gidx     = '0;
    locked   = 1'b0;
    scan_idx = '0;
    case (MODE)
      1: begin
        // Walk downwards so the lowest valid index is the last one written.
        for (int i = NCH - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            gany = 1'b1;
            gidx = SELW'(i);
          end
        end
      end
      2: begin
        if (int'(sel) < NCH) begin
          gany = 1'b1;
          gidx = sel;
        end
      end
      default: begin
        locked = (cnt != '0) && in_valid[owner];
        if (locked) begin
          gany = 1'b1;
          gidx = owner;
        end else begin
          // Reverse scan from ptr: the nearest valid channel after ptr wins.
          for (int off = NCH - 1; off >= 0; off--) begin
            scan_idx = SELW'((int'(ptr) + off) % NCH);
            if (in_valid[scan_idx]) begin
              gany = 1'b1;
              gidx = scan_idx;
            end
          end
        end
      end
    endcase
  end

  assign grant    = gany ? (NCH'(1) << gidx) : '0;
  assign in_ready = load ? grant : '0;
  assign xfer     = gany && load && in_valid[gidx];

  always_comb begin
    burst_c = locked ? int'(cnt) + 1 : 1;
    cnt_nxt = (burst_c == BURST) ? '0 : CNTW'(burst_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
    end else begin
      if (xfer) begin
        out_data  <= in_data[int'(gidx)*WIDTH +: WIDTH];
        out_chan  <= gidx;
        out_valid <= 1'b1;
      end else if (load) begin
        out_valid <= 1'b0;
      end
      if (MODE == 0) begin
        if (xfer) begin
          owner <= gidx;
          ptr   <= SELW'((int'(gidx) + 1) % NCH);
          cnt   <= cnt_nxt;
        end else if ((cnt != '0) && !in_valid[owner]) begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: round-robin (burst 1 and 3), fixed priority and manual instances.
module tb_stream_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d4 = '0;
  logic [3:0]  v4 = '0;
  logic [1:0]  sel2 = '0;
  logic [39:0] d5 = '0;
  logic [4:0]  v5 = '0;
  logic [2:0]  sel3 = '0;
  logic        ordy = 1'b0;

  logic [3:0] rr1_rdy, rr3_rdy, pri_rdy;
  logic [7:0] rr1_dat, rr3_dat, pri_dat, man_dat;
  logic [1:0] rr1_chan, rr3_chan, pri_chan;
  logic       rr1_vld, rr3_vld, pri_vld, man_vld;
  logic [4:0] man_rdy;
  logic [2:0] man_chan;

  int vec = 0;
  int errs = 0;
  int pushes = 0;
  int pops = 0;

  always #5 clk = ~clk;

  stream_mux_arb #(.WIDTH(8), .NCH(4), .MODE(0), .BURST(1)) dut_rr1 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(rr1_rdy), .sel(sel2),
    .out_data(rr1_dat), .out_chan(rr1_chan), .out_valid(rr1_vld), .out_ready(ordy));

  stream_mux_arb #(.WIDTH(8), .NCH(4), .MODE(0), .BURST(3)) dut_rr3 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(rr3_rdy), .sel(sel2),
    .out_data(rr3_dat), .out_chan(rr3_chan), .out_valid(rr3_vld), .out_ready(ordy));

  stream_mux_arb #(.WIDTH(8), .NCH(4), .MODE(1), .BURST(1)) dut_pri (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(pri_rdy), .sel(sel2),
    .out_data(pri_dat), .out_chan(pri_chan), .out_valid(pri_vld), .out_ready(ordy));

  // Five channels so that a 3-bit select can name a channel that does not exist.
  stream_mux_arb #(.WIDTH(8), .NCH(5), .MODE(2), .BURST(1)) dut_man (
    .clk(clk), .rst_n(rst_n), .in_data(d5), .in_valid(v5), .in_ready(man_rdy), .sel(sel3),
    .out_data(man_dat), .out_chan(man_chan), .out_valid(man_vld), .out_ready(ordy));

  task automatic tick();
    if (v4[0] && rr1_rdy[0]) pushes++;
    if (rr1_vld && ordy) pops++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    v4 = '0;
    v5 = '0;
    ordy = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pushes = 0;
    pops = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    d4 = 32'hC3C2C1C0;
    v4 = 4'b1111;
    #1;
    vec++; if (rr1_vld !== 1'b0) begin errs++; $display("FAIL reset_valid: got %0b expected 0", rr1_vld); end
    vec++; if (rr1_dat !== 8'h00) begin errs++; $display("FAIL reset_data: got %0h expected 00", rr1_dat); end
    vec++; if (rr1_chan !== 2'd0) begin errs++; $display("FAIL reset_chan: got %0d expected 0", rr1_chan); end
    vec++; if (rr1_rdy !== 4'b0001) begin errs++; $display("FAIL reset_ready: got %b expected 0001", rr1_rdy); end
    tick();
    vec++; if (rr1_vld !== 1'b1) begin errs++; $display("FAIL pre_reset_valid: got %0b expected 1", rr1_vld); end
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if (rr1_vld !== 1'b0) begin errs++; $display("FAIL async_reset_valid: got %0b expected 0", rr1_vld); end
    vec++; if (rr1_dat !== 8'h00) begin errs++; $display("FAIL async_reset_data: got %0h expected 00", rr1_dat); end
    vec++; if (rr1_chan !== 2'd0) begin errs++; $display("FAIL async_reset_chan: got %0d expected 0", rr1_chan); end
    v4 = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vec++; if (rr1_vld !== 1'b0) begin errs++; $display("FAIL idle_valid[%0d]: got %0b expected 0", k, rr1_vld); end
    end
  endtask

  task automatic test_rr_burst1();
    apply_reset();
    d4 = 32'hC3C2C1C0;
    v4 = 4'b1111;
    ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      vec++; if (rr1_rdy !== 4'(1 << (k % 4))) begin errs++; $display("FAIL rr1_ready[%0d]: got %b expected %b", k, rr1_rdy, 4'(1 << (k % 4))); end
      tick();
      vec++; if (rr1_vld !== 1'b1) begin errs++; $display("FAIL rr1_valid[%0d]: got %0b expected 1", k, rr1_vld); end
      vec++; if (rr1_chan !== 2'(k % 4)) begin errs++; $display("FAIL rr1_chan[%0d]: got %0d expected %0d", k, rr1_chan, k % 4); end
      vec++; if (rr1_dat !== 8'(8'hC0 + k % 4)) begin errs++; $display("FAIL rr1_data[%0d]: got %0h expected %0h", k, rr1_dat, 8'hC0 + k % 4); end
    end
  endtask

  task automatic test_rr_burst3();
    int exp3 [8] = '{1, 1, 1, 2, 2, 2, 1, 1};
    apply_reset();
    d4 = 32'hC3C2C1C0;
    v4 = 4'b0110;
    ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      vec++; if (rr3_rdy !== 4'(1 << exp3[k])) begin errs++; $display("FAIL rr3_ready[%0d]: got %b expected %b", k, rr3_rdy, 4'(1 << exp3[k])); end
      tick();
      vec++; if (rr3_chan !== 2'(exp3[k])) begin errs++; $display("FAIL rr3_chan[%0d]: got %0d expected %0d", k, rr3_chan, exp3[k]); end
    end
    apply_reset();
    v4 = 4'b0110;
    ordy = 1'b1;
    tick();
    tick();
    vec++; if (rr3_chan !== 2'd1) begin errs++; $display("FAIL rr3_lock_chan: got %0d expected 1", rr3_chan); end
    v4 = 4'b0100;
    #1;
    vec++; if (rr3_rdy !== 4'b0100) begin errs++; $display("FAIL rr3_drop_ready: got %b expected 0100", rr3_rdy); end
    tick();
    vec++; if (rr3_chan !== 2'd2) begin errs++; $display("FAIL rr3_drop_chan: got %0d expected 2", rr3_chan); end
  endtask

  task automatic test_priority();
    apply_reset();
    d4 = 32'hC3C2C1C0;
    v4 = 4'b1001;
    ordy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      vec++; if (pri_rdy !== 4'b0001) begin errs++; $display("FAIL pri_ready[%0d]: got %b expected 0001", k, pri_rdy); end
      tick();
      vec++; if (pri_chan !== 2'd0 || pri_vld !== 1'b1) begin errs++; $display("FAIL pri_chan[%0d]: got %0d/%0b expected 0/1", k, pri_chan, pri_vld); end
    end
    v4 = 4'b1000;
    #1;
    vec++; if (pri_rdy !== 4'b1000) begin errs++; $display("FAIL pri_ready_ch3: got %b expected 1000", pri_rdy); end
    tick();
    vec++; if (pri_chan !== 2'd3) begin errs++; $display("FAIL pri_chan_ch3: got %0d expected 3", pri_chan); end
    vec++; if (pri_dat !== 8'hC3) begin errs++; $display("FAIL pri_data_ch3: got %0h expected c3", pri_dat); end
  endtask

  task automatic test_manual();
    apply_reset();
    d5 = 40'hC4C3C2C1C0;
    v5 = 5'b11111;
    sel3 = 3'd2;
    ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vec++; if (man_rdy !== 5'b00100) begin errs++; $display("FAIL man_ready[%0d]: got %b expected 00100", k, man_rdy); end
      tick();
      vec++; if (man_chan !== 3'd2 || man_dat !== 8'hC2) begin errs++; $display("FAIL man_beat[%0d]: got %0d/%0h expected 2/c2", k, man_chan, man_dat); end
    end
    sel3 = 3'd5;
    for (int k = 0; k < 2; k++) begin
      #1;
      vec++; if (man_rdy !== 5'b00000) begin errs++; $display("FAIL man_oob_ready[%0d]: got %b expected 00000", k, man_rdy); end
      tick();
      vec++; if (man_vld !== 1'b0) begin errs++; $display("FAIL man_oob_valid[%0d]: got %0b expected 0", k, man_vld); end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    d4 = 32'hC3C2C1A5;
    v4 = 4'b0001;
    ordy = 1'b0;
    #1;
    vec++; if (rr1_rdy !== 4'b0001) begin errs++; $display("FAIL bp_first_ready: got %b expected 0001", rr1_rdy); end
    tick();
    vec++; if (rr1_dat !== 8'hA5 || rr1_vld !== 1'b1) begin errs++; $display("FAIL bp_load: got %0h/%0b expected a5/1", rr1_dat, rr1_vld); end
    d4[7:0] = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      #1;
      vec++; if (rr1_rdy !== 4'b0000) begin errs++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, rr1_rdy); end
      tick();
      vec++; if (rr1_dat !== 8'hA5 || rr1_vld !== 1'b1 || rr1_chan !== 2'd0) begin errs++; $display("FAIL bp_hold[%0d]: got %0h/%0b/%0d expected a5/1/0", k, rr1_dat, rr1_vld, rr1_chan); end
    end
    ordy = 1'b1;
    #1;
    vec++; if (rr1_rdy !== 4'b0001) begin errs++; $display("FAIL bp_release_ready: got %b expected 0001", rr1_rdy); end
    tick();
    vec++; if (rr1_dat !== 8'h5A || rr1_vld !== 1'b1) begin errs++; $display("FAIL bp_overwrite: got %0h/%0b expected 5a/1", rr1_dat, rr1_vld); end
    v4 = 4'b0000;
    tick();
    vec++; if (rr1_vld !== 1'b0) begin errs++; $display("FAIL bp_drain_valid: got %0b expected 0", rr1_vld); end
    vec++; if (pushes !== 2 || pops !== 2) begin errs++; $display("FAIL bp_scoreboard: got %0d pushes %0d pops expected 2/2", pushes, pops); end
  endtask

  initial begin
    test_reset();
    test_rr_burst1();
    test_rr_burst3();
    test_priority();
    test_manual();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
